pid_step_scheduler: RTL and testbench

- Per-time-step sequencer for the time-multiplexed 64-bit PID/transfer-function datapath shared by N_UNITS wind-turbine instances.
- On each step request it issues, in fixed order:
  - the FIFO read-ahead strobe (done_read);
  - the initialisation controls (rst_user, control_valuation_sig) when an init is pending;
  - the burst-start strobe (sta).
- It then waits out pipeline latency plus the N_UNITS burst and reports step completion to the system-level step controller.

---
 rtl/pid_step_scheduler.sv | 124 ++++++++++++
 tb/tb_pid_step_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_step_scheduler.sv
// rtl/pid_step_scheduler.sv - per-step strobe sequencer for the shared PID/transfer-function datapath
module pid_step_scheduler #(
    parameter int N_UNITS   = 8,
    parameter int READ_LEAD = 10,
    parameter int PIPE_LAT  = 20,
    parameter int CW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_start,
    input  logic          init_req,
    output logic          done_read,
    output logic          sta,
    output logic          rst_user,
    output logic          control_valuation_sig,
    output logic          busy,
    output logic          step_done,
    output logic [CW-1:0] step_cnt,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, LEAD, DRAIN, DONE} state_t;

    // 17 bits covers PIPE_LAT + N_UNITS - 1 at the largest legal parameter values
    localparam int CNTW = 17;
    localparam logic [CNTW-1:0] LEAD_LOAD  = CNTW'(READ_LEAD - 1);
    localparam logic [CNTW-1:0] DRAIN_LOAD = CNTW'(PIPE_LAT + N_UNITS - 1);

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            init_pend, init_pend_nxt;
    logic            done_read_nxt, sta_nxt, rst_user_nxt, cvs_nxt;
    logic            busy_nxt, step_done_nxt, overrun_nxt;
    logic [CW-1:0]   step_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            cnt                   <= '0;
            init_pend             <= 1'b1;
            done_read             <= 1'b0;
            sta                   <= 1'b0;
            rst_user              <= 1'b0;
            control_valuation_sig <= 1'b0;
            busy                  <= 1'b0;
            step_done             <= 1'b0;
            step_cnt              <= '0;
            overrun               <= 1'b0;
        end else begin
            state                 <= state_nxt;
            cnt                   <= cnt_nxt;
            init_pend             <= init_pend_nxt;
            done_read             <= done_read_nxt;
            sta                   <= sta_nxt;
            rst_user              <= rst_user_nxt;
            control_valuation_sig <= cvs_nxt;
            busy                  <= busy_nxt;
            step_done             <= step_done_nxt;
            step_cnt              <= step_cnt_nxt;
            overrun               <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        init_pend_nxt = init_pend;
        done_read_nxt = 1'b0;
        sta_nxt       = 1'b0;
        rst_user_nxt  = 1'b0;
        cvs_nxt       = 1'b0;
        busy_nxt      = busy;
        step_done_nxt = 1'b0;
        step_cnt_nxt  = step_cnt;
        overrun_nxt   = overrun;

        case (state)
            IDLE, DONE: begin
                busy_nxt = 1'b0;
                if (step_start) begin
                    state_nxt     = LEAD;
                    cnt_nxt       = LEAD_LOAD;
                    done_read_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    // a coincident init_req applies to the step being accepted
                    if (init_pend || init_req) begin
                        rst_user_nxt  = 1'b1;
                        cvs_nxt       = 1'b1;
                        init_pend_nxt = 1'b0;
                        step_cnt_nxt  = '0;
                    end
                end else begin
                    state_nxt = IDLE;
                    if (init_req) init_pend_nxt = 1'b1;
                end
            end
            LEAD: begin
                if (init_req)   init_pend_nxt = 1'b1;
                if (step_start) overrun_nxt   = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                    sta_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DRAIN: begin
                if (init_req)   init_pend_nxt = 1'b1;
                if (step_start) overrun_nxt   = 1'b1;
                if (cnt == '0) begin
                    state_nxt     = DONE;
                    step_done_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    step_cnt_nxt  = step_cnt + 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pid_step_scheduler.sv
// tb/tb_pid_step_scheduler.sv - scoreboard bench for pid_step_scheduler (default and minimal configs)
module tb_pid_step_scheduler;

    localparam int LA = 10;
    localparam int DA = 28;
    localparam int LB = 1;
    localparam int DB = 2;

    typedef struct {
        int       cyc;
        logic [4:0] strb;
        int       cnt;
        bit       chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic rst_a, step_a, init_a;
    logic dr_a, sta_a, ru_a, cvs_a, busy_a, sd_a, ovr_a;
    logic [31:0] cnt_a;
    logic rst_b, step_b, init_b;
    logic dr_b, sta_b, ru_b, cvs_b, busy_b, sd_b, ovr_b;
    logic [3:0] cnt_b;

    pid_step_scheduler dut_a (
        .clk(clk), .rst(rst_a), .step_start(step_a), .init_req(init_a),
        .done_read(dr_a), .sta(sta_a), .rst_user(ru_a), .control_valuation_sig(cvs_a),
        .busy(busy_a), .step_done(sd_a), .step_cnt(cnt_a), .overrun(ovr_a)
    );

    pid_step_scheduler #(.N_UNITS(1), .READ_LEAD(1), .PIPE_LAT(1), .CW(4)) dut_b (
        .clk(clk), .rst(rst_b), .step_start(step_b), .init_req(init_b),
        .done_read(dr_b), .sta(sta_b), .rst_user(ru_b), .control_valuation_sig(cvs_b),
        .busy(busy_b), .step_done(sd_b), .step_cnt(cnt_b), .overrun(ovr_b)
    );

    int cyc_a, cyc_b;
    always @(posedge clk or negedge rst_a) if (!rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // scoreboard monitors: every strobe-bearing cycle pops one expected event
    bit cpend_a = 0, cpend_b = 0;
    int cexp_a, cexp_b;

    always @(negedge clk) begin
        exp_t e;
        logic [4:0] sv;
        if (rst_a) begin
            if (cpend_a) begin
                chk("step_cnt_a", cnt_a, cexp_a);
                cpend_a <= 0;
            end
            sv = {sd_a, sta_a, cvs_a, ru_a, dr_a};
            if (sv != 5'b0) begin
                if (q_a.size() == 0) chk("unexpected_strobe_a", {27'b0, sv}, 0);
                else begin
                    e = q_a.pop_front();
                    chk("cycle_a", cyc_a, e.cyc);
                    chk("strobes_a", {27'b0, sv}, {27'b0, e.strb});
                    if (e.chk) begin cpend_a <= 1; cexp_a <= e.cnt; end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic [4:0] sv;
        if (rst_b) begin
            if (cpend_b) begin
                chk("step_cnt_b", {28'b0, cnt_b}, cexp_b);
                cpend_b <= 0;
            end
            sv = {sd_b, sta_b, cvs_b, ru_b, dr_b};
            if (sv != 5'b0) begin
                if (q_b.size() == 0) chk("unexpected_strobe_b", {27'b0, sv}, 0);
                else begin
                    e = q_b.pop_front();
                    chk("cycle_b", cyc_b, e.cyc);
                    chk("strobes_b", {27'b0, sv}, {27'b0, e.strb});
                    if (e.chk) begin cpend_b <= 1; cexp_b <= e.cnt; end
                end
            end
        end
    end

    task automatic wait_a(input int c);
        while (cyc_a < c) @(negedge clk);
    endtask

    task automatic wait_b(input int c);
        while (cyc_b < c) @(negedge clk);
    endtask

    task automatic pulse_a(input int t, input bit s, input bit i);
        wait_a(t);
        step_a = s; init_a = i;
        @(posedge clk); #1;
        step_a = 0; init_a = 0;
    endtask

    task automatic pulse_b(input int t, input bit s, input bit i);
        wait_b(t);
        step_b = s; init_b = i;
        @(posedge clk); #1;
        step_b = 0; init_b = 0;
    endtask

    task automatic do_step_a(input int t, input bit ireq, input bit emit, input int cnt, input bit full);
        q_a.push_back('{cyc: t + 1, strb: {2'b00, emit, emit, 1'b1}, cnt: 0, chk: 1'b0});
        q_a.push_back('{cyc: t + 1 + LA, strb: 5'b01000, cnt: 0, chk: 1'b0});
        if (full) q_a.push_back('{cyc: t + 1 + LA + DA, strb: 5'b10000, cnt: cnt, chk: 1'b1});
        pulse_a(t, 1'b1, ireq);
    endtask

    task automatic do_step_b(input int t, input bit emit, input int cnt);
        q_b.push_back('{cyc: t + 1, strb: {2'b00, emit, emit, 1'b1}, cnt: 0, chk: 1'b0});
        q_b.push_back('{cyc: t + 1 + LB, strb: 5'b01000, cnt: 0, chk: 1'b0});
        q_b.push_back('{cyc: t + 1 + LB + DB, strb: 5'b10000, cnt: cnt, chk: 1'b1});
        pulse_b(t, 1'b1, 1'b0);
    endtask

    task automatic seq_a();
        int t;
        // first step picks up the init pending from reset
        wait_a(5);
        chk("busy_before_a", {31'b0, busy_a}, 0);
        do_step_a(5, 0, 1, 1, 1);
        wait_a(6);  chk("busy_first_a", {31'b0, busy_a}, 1);
        chk("cnt_cleared_a", cnt_a, 0);
        wait_a(43); chk("busy_last_a", {31'b0, busy_a}, 1);
        wait_a(44); chk("busy_done_a", {31'b0, busy_a}, 0);
        do_step_a(50, 0, 0, 2, 1);
        // idle init_req emits nothing, then five back-to-back steps
        pulse_a(92, 0, 1);
        t = 95;
        for (int k = 1; k <= 5; k++) begin
            do_step_a(t, 0, k == 1, k, 1);
            t = t + 1 + LA + DA;
        end
        // overrun and init_req while busy
        wait_a(300); chk("overrun_clear_a", {31'b0, ovr_a}, 0);
        do_step_a(300, 0, 0, 6, 1);
        pulse_a(316, 1, 0);
        wait_a(317); chk("overrun_set_a", {31'b0, ovr_a}, 1);
        pulse_a(320, 0, 1);
        wait_a(340); chk("overrun_sticky_a", {31'b0, ovr_a}, 1);
        do_step_a(345, 0, 1, 1, 1);
        wait_a(346); chk("cnt_reinit_a", cnt_a, 0);
        // asynchronous reset three cycles after sta
        do_step_a(390, 0, 0, 0, 0);
        wait_a(404);
        #2 rst_a = 0;
        #1 chk("async_reset_a", {25'b0, dr_a, sta_a, ru_a, cvs_a, busy_a, sd_a, ovr_a}, 0);
        chk("async_reset_cnt_a", cnt_a, 0);
        repeat (3) @(negedge clk);
        rst_a = 1;
        wait_a(10);
        chk("post_reset_quiet_a", {25'b0, dr_a, sta_a, ru_a, cvs_a, busy_a, sd_a, ovr_a}, 0);
        do_step_a(20, 0, 1, 1, 1);
        do_step_a(65, 1, 1, 1, 1);
        wait_a(110);
    endtask

    task automatic seq_b();
        int t;
        t = 3;
        for (int k = 1; k <= 17; k++) begin
            do_step_b(t, k == 1, k % 16);
            if (k == 1) begin
                wait_b(4); chk("busy_lead_b", {31'b0, busy_b}, 1);
                wait_b(6); chk("busy_drain_b", {31'b0, busy_b}, 1);
                wait_b(7); chk("busy_done_b", {31'b0, busy_b}, 0);
            end
            t = t + 1 + LB + DB;
        end
        wait_b(t + 4);
        chk("overrun_b", {31'b0, ovr_b}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_a = 0; rst_b = 0;
        step_a = 0; init_a = 0; step_b = 0; init_b = 0;
        #3;
        chk("reset_a", {25'b0, dr_a, sta_a, ru_a, cvs_a, busy_a, sd_a, ovr_a}, 0);
        chk("reset_cnt_a", cnt_a, 0);
        chk("reset_b", {24'b0, cnt_b, dr_b, sta_b, ru_b, cvs_b}, 0);
        repeat (3) @(negedge clk);
        rst_a = 1; rst_b = 1;
        fork
            seq_a();
            seq_b();
        join
        repeat (5) @(negedge clk);
        chk("queue_empty_a", q_a.size(), 0);
        chk("queue_empty_b", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
